// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle EX waits, plus a saturating count of front-end stall cycles.
module hazard_stall_ctrl #(
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_mem_read,
   input  logic             branch_taken,
   input  logic             mc_start,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Write,
   output logic             IDEX_Bubble,
   output logic             EXMEM_Bubble,
   output logic             mc_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] MC_INIT = 8'(MC_LAT - 1);

   state_t             state_q, state_d;
   logic [7:0]         mc_cnt_q, mc_cnt_d;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
   logic               load_use_s;
   logic               pc_write_s, ifid_write_s, ifid_flush_s;
   logic               idex_write_s, idex_bubble_s, exmem_bubble_s, mc_busy_s;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use_s = idex_mem_read && (idex_rd != 5'd0) &&
                       ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

   // Next-state, counter and output decode.
   always_comb begin
      state_d        = state_q;
      mc_cnt_d       = mc_cnt_q;
      pc_write_s     = 1'b1;
      ifid_write_s   = 1'b1;
      ifid_flush_s   = 1'b0;
      idex_write_s   = 1'b1;
      idex_bubble_s  = 1'b0;
      exmem_bubble_s = 1'b0;
      mc_busy_s      = 1'b0;
      if (reset) begin
         pc_write_s    = 1'b0;
         ifid_write_s  = 1'b0;
         ifid_flush_s  = 1'b1;
         idex_bubble_s = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (branch_taken) begin
                  ifid_flush_s  = 1'b1;
                  idex_bubble_s = 1'b1;
               end else if (load_use_s && !mc_start) begin
                  pc_write_s    = 1'b0;
                  ifid_write_s  = 1'b0;
                  idex_bubble_s = 1'b1;
               end else begin
                  pc_write_s    = 1'b1;
               end
               if (mc_start) begin
                  state_d  = MC_WAIT;
                  mc_cnt_d = MC_INIT;
               end else begin
                  state_d  = RUN;
               end
            end
            MC_WAIT: begin
               pc_write_s     = 1'b0;
               ifid_write_s   = 1'b0;
               idex_write_s   = 1'b0;
               exmem_bubble_s = 1'b1;
               mc_busy_s      = 1'b1;
               mc_cnt_d       = mc_cnt_q - 8'd1;
               if (mc_cnt_q == 8'd1) begin
                  state_d = RUN;
               end else begin
                  state_d = MC_WAIT;
               end
            end
            default: begin
               state_d  = RUN;
               mc_cnt_d = 8'd0;
            end
         endcase
      end
      // Saturate instead of wrapping so a long run never reports a small count.
      if (!reset && !pc_write_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         mc_cnt_q       <= 8'd0;
         stall_cycles_q <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         mc_cnt_q       <= mc_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign PC_Write     = pc_write_s;
   assign IFID_Write   = ifid_write_s;
   assign IFID_Flush   = ifid_flush_s;
   assign IDEX_Write   = idex_write_s;
   assign IDEX_Bubble  = idex_bubble_s;
   assign EXMEM_Bubble = exmem_bubble_s;
   assign mc_busy      = mc_busy_s;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table for single-cycle RUN
// decoding plus hand-written multi-cycle wait, reset-abort and saturation sequences.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
   logic        idex_mem_read, branch_taken, mc_start;
   logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_b, busy;
   logic [31:0] stall;
   logic        pc_w2, ifid_w2, ifid_f2, idex_w2, idex_b2, exmem_b2, busy2;
   logic [3:0]  stall2;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
      .mc_start(mc_start), .PC_Write(pc_w), .IFID_Write(ifid_w), .IFID_Flush(ifid_f),
      .IDEX_Write(idex_w), .IDEX_Bubble(idex_b), .EXMEM_Bubble(exmem_b),
      .mc_busy(busy), .stall_cycles(stall));

   hazard_stall_ctrl #(.MC_LAT(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
      .mc_start(mc_start), .PC_Write(pc_w2), .IFID_Write(ifid_w2), .IFID_Flush(ifid_f2),
      .IDEX_Write(idex_w2), .IDEX_Bubble(idex_b2), .EXMEM_Bubble(exmem_b2),
      .mc_busy(busy2), .stall_cycles(stall2));

   // Output bundle order: PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, mc_busy
   localparam logic [6:0] O_RUN    = 7'b1101000;
   localparam logic [6:0] O_STALL  = 7'b0001100;
   localparam logic [6:0] O_BRANCH = 7'b1111100;
   localparam logic [6:0] O_WAIT   = 7'b0000011;
   localparam logic [6:0] O_RESET  = 7'b0011100;

   typedef struct {
      string      name;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mr;
      logic       bt;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [6:0] outs();
      return {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_b, busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic bt, input logic mc);
      ifid_rs1 = rs1; ifid_rs2 = rs2; idex_rd = rd;
      idex_mem_read = mr; branch_taken = bt; mc_start = mc;
   endtask

   // One cycle: inputs already driven; check outputs mid-cycle, then advance past the edge.
   task automatic cycle(input string name, input logic [6:0] exp);
      @(negedge clk);
      chk(name, {25'd0, outs()}, {25'd0, exp});
      if (exp[6] == 1'b0 && reset == 1'b0) exp_stall++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"run_nomatch",  5'd1,  5'd2,  5'd3,  1'b1, 1'b0, O_RUN};
      vecs[1] = '{"lu_rs2",       5'd7,  5'd5,  5'd5,  1'b1, 1'b0, O_STALL};
      vecs[2] = '{"x0_load",      5'd0,  5'd0,  5'd0,  1'b1, 1'b0, O_RUN};
      vecs[3] = '{"no_load",      5'd9,  5'd3,  5'd9,  1'b0, 1'b0, O_RUN};
      vecs[4] = '{"lu_rs1",       5'd9,  5'd3,  5'd9,  1'b1, 1'b0, O_STALL};
      vecs[5] = '{"br_over_lu",   5'd9,  5'd3,  5'd9,  1'b1, 1'b1, O_BRANCH};
      vecs[6] = '{"lu_both",      5'd4,  5'd4,  5'd4,  1'b1, 1'b0, O_STALL};
      vecs[7] = '{"br_plain",     5'd1,  5'd2,  5'd3,  1'b0, 1'b1, O_BRANCH};
      vecs[8] = '{"lu_r31",       5'd31, 5'd0,  5'd31, 1'b1, 1'b0, O_STALL};
      vecs[9] = '{"idle",         5'd0,  5'd0,  5'd0,  1'b0, 1'b0, O_RUN};

      // Reset held for three cycles
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cycle("reset_outs", O_RESET);
      reset = 1'b0;
      exp_stall = 0;
      chk("reset_stall", stall, 32'd0);
      cycle("post_reset_run", O_RUN);

      // Single-cycle RUN decoding
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].bt, 1'b0);
         cycle(vecs[i].name, vecs[i].exp);
         chk({vecs[i].name, "_stall"}, stall, exp_stall);
      end

      // Multi-cycle op: three wait cycles, branch and load-use ignored mid-wait
      begin
         int base;
         base = exp_stall;
         drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
         cycle("mc_start_cyc", O_RUN);
         drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         cycle("mc_wait1", O_WAIT);
         drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1);
         cycle("mc_wait2_ignore", O_WAIT);
         drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         cycle("mc_wait3", O_WAIT);
         cycle("mc_back_run", O_RUN);
         chk("mc_stall_delta", stall - 32'(base), 32'd3);
      end

      // Branch and mc_start together: flush now, wait anyway
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle("br_mc_same", O_BRANCH);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("br_mc_wait", O_WAIT);
      cycle("br_mc_run", O_RUN);
      chk("br_mc_stall", stall, exp_stall);

      // Reset in the second wait cycle aborts the wait
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle("abort_start", O_RUN);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("abort_wait1", O_WAIT);
      reset = 1'b1;
      cycle("abort_reset", O_RESET);
      reset = 1'b0;
      exp_stall = 0;
      chk("abort_stall", stall, 32'd0);
      cycle("abort_run", O_RUN);
      chk("abort_busy", {31'd0, busy}, 32'd0);

      // Continuous load-use saturates the 4-bit counter
      drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("sat_stall", O_STALL);
      chk("sat_wide", stall, 32'd20);
      chk("sat_narrow", {28'd0, stall2}, 32'd15);
      cycle("sat_hold", O_STALL);
      chk("sat_narrow_hold", {28'd0, stall2}, 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
